// File: rtl/input_debounce.sv
// input_debounce: multi-channel synchroniser, debouncer and edge/flag reporter.
// Each channel runs an independent stable-cycle counter. A new level is accepted
// only after the synchronised input has differed from the current level for
// DEBOUNCE_CYCLES consecutive enabled cycles.
module input_debounce #(
    parameter int WIDTH           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter bit RESET_VAL       = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] in,
    input  logic [WIDTH-1:0] clr_flags,
    output logic [WIDTH-1:0] level_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] flags
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } chan_state_t;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] s;
    logic [CNT_W-1:0] cnt_q  [WIDTH];
    logic [CNT_W-1:0] cnt_d  [WIDTH];
    chan_state_t      state  [WIDTH];
    logic [WIDTH-1:0] level_d;
    logic [WIDTH-1:0] rise_d;
    logic [WIDTH-1:0] fall_d;

    // Counter step that wraps to zero at the acceptance point, so the count
    // can never pass DEBOUNCE_CYCLES-1.
    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        if (c == CNT_LAST)
            return '0;
        return c + CNT_W'(1);
    endfunction

    // Plain flop chain per channel; the last stage is the clean sample s.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++)
                sync_q[k] <= {WIDTH{RESET_VAL}};
        end else begin
            sync_q[0] <= in;
            for (int k = 1; k < SYNC_STAGES; k++)
                sync_q[k] <= sync_q[k-1];
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Per-channel next state: clear when stable, count while pending, accept at the last count.
    always_comb begin
        level_d = level_out;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            state[i] = ST_STABLE;
            cnt_d[i] = '0;
        end
        for (int i = 0; i < WIDTH; i++) begin
            state[i] = (s[i] != level_out[i]) ? ST_PENDING : ST_STABLE;
            case (state[i])
                ST_STABLE: begin
                    cnt_d[i] = '0;
                end
                ST_PENDING: begin
                    // With en low the counter stays cleared, so a full window
                    // is required again once enable returns.
                    if (en) begin
                        if (cnt_q[i] == CNT_LAST) begin
                            level_d[i] = s[i];
                            rise_d[i]  = s[i];
                            fall_d[i]  = ~s[i];
                            cnt_d[i]   = '0;
                        end else begin
                            cnt_d[i] = cnt_inc(cnt_q[i]);
                        end
                    end
                end
                default: begin
                    cnt_d[i] = '0;
                end
            endcase
        end
    end

    // Counters, accepted level and the single-cycle edge pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_out <= {WIDTH{RESET_VAL}};
            rise      <= '0;
            fall      <= '0;
            for (int i = 0; i < WIDTH; i++)
                cnt_q[i] <= '0;
        end else begin
            level_out <= level_d;
            rise      <= rise_d;
            fall      <= fall_d;
            for (int i = 0; i < WIDTH; i++)
                cnt_q[i] <= cnt_d[i];
        end
    end

    // Sticky change flags; a new edge wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst)
            flags <= '0;
        else
            flags <= (flags & ~clr_flags) | rise | fall;
    end

endmodule

// File: tb/tb_input_debounce.sv
// Bench for input_debounce: directed stimulus pushes expected edge events into
// a queue; a monitor pops and compares whenever a rise/fall pulse appears.
module tb_input_debounce;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b1;
    logic [3:0] in  = 4'b0000;
    logic [3:0] clr_flags = 4'b0000;
    logic [3:0] level_out, rise, fall, flags;

    int total = 0;
    int bad   = 0;
    int edge_n = 0;

    typedef struct {
        int         at;
        logic [3:0] r;
        logic [3:0] f;
        logic [3:0] l;
        logic [3:0] fl;
    } evt_t;

    evt_t q[$];
    evt_t e;
    int         flag_at  = -1;
    logic [3:0] flag_exp = 4'b0000;

    input_debounce #(
        .WIDTH(4),
        .SYNC_STAGES(2),
        .DEBOUNCE_CYCLES(4),
        .RESET_VAL(1'b0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .in(in),
        .clr_flags(clr_flags),
        .level_out(level_out),
        .rise(rise),
        .fall(fall),
        .flags(flags)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int at, input logic [3:0] r, input logic [3:0] f,
                        input logic [3:0] l, input logic [3:0] fl);
        evt_t x;
        x.at = at; x.r = r; x.f = f; x.l = l; x.fl = fl;
        q.push_back(x);
    endtask

    // Monitor: sample away from the active edge, pop on every presented pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (q.size() > 0 && edge_n > q[0].at) begin
                total++;
                bad++;
                $display("FAIL missing_event: expected at edge %0d, none by edge %0d", q[0].at, edge_n);
                void'(q.pop_front());
            end
            if ((rise | fall) !== 4'b0000) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pulse: rise=%b fall=%b at edge %0d, none expected", rise, fall, edge_n);
                end else begin
                    e = q.pop_front();
                    check_int("event_edge", edge_n, e.at);
                    check4("rise", rise, e.r);
                    check4("fall", fall, e.f);
                    check4("level_out", level_out, e.l);
                    flag_at  = e.at + 1;
                    flag_exp = e.fl;
                end
            end
            if (flag_at == edge_n) begin
                check4("flags_after_event", flags, flag_exp);
                flag_at = -1;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        step(2);
        check4("reset_level", level_out, 4'b0000);
        check4("reset_rise", rise, 4'b0000);
        check4("reset_fall", fall, 4'b0000);
        check4("reset_flags", flags, 4'b0000);
        rst = 1'b0;

        // Basic rise on ch0: 2 sync + 4 debounce edges
        in = 4'b0001;
        push(edge_n + 6, 4'b0001, 4'b0000, 4'b0001, 4'b0001);
        step(8);

        // Glitch on ch1 lasting 3 cycles is rejected
        in = 4'b0011;
        step(3);
        in = 4'b0001;
        step(8);
        check4("glitch_level", level_out, 4'b0001);
        check4("glitch_flags", flags, 4'b0001);

        // Bounce on ch2: 1,0,1,0,1 at 2-cycle intervals
        in = 4'b0101; step(2);
        in = 4'b0001; step(2);
        in = 4'b0101; step(2);
        in = 4'b0001; step(2);
        in = 4'b0101;
        push(edge_n + 6, 4'b0100, 4'b0000, 4'b0101, 4'b0101);
        step(10);

        // Three channels change together
        in = 4'b1000;
        push(edge_n + 6, 4'b1000, 4'b0101, 4'b1000, 4'b1101);
        step(8);
        clr_flags = 4'b1111;
        step(1);
        clr_flags = 4'b0000;
        check4("clear_all_flags", flags, 4'b0000);

        // Simultaneous rise[0] and fall[3] from level 1000
        in = 4'b0001;
        push(edge_n + 6, 4'b0001, 4'b1000, 4'b0001, 4'b1001);
        step(8);
        clr_flags = 4'b1111;
        step(1);
        clr_flags = 4'b0000;

        // Enable dropped after 2 pending cycles on ch0, held low 5 cycles
        in = 4'b0000;
        step(4);
        en = 1'b0;
        step(5);
        check4("en_low_level_held", level_out, 4'b0001);
        en = 1'b1;
        push(edge_n + 4, 4'b0000, 4'b0001, 4'b0000, 4'b0001);
        step(4);
        // Clear coincides with the flag set: set must win
        clr_flags = 4'b0001;
        step(1);
        clr_flags = 4'b0000;
        step(2);
        check4("flag_set_wins", flags, 4'b0001);
        clr_flags = 4'b0001;
        step(1);
        clr_flags = 4'b0000;
        check4("lone_clear", flags, 4'b0000);

        // Reset mid-debounce: ch3 counter at 2 when reset hits
        in = 4'b0001;
        push(edge_n + 6, 4'b0001, 4'b0000, 4'b0001, 4'b0001);
        step(8);
        in = 4'b1001;
        step(4);
        rst = 1'b1;
        step(1);
        check4("midrst_level", level_out, 4'b0000);
        check4("midrst_rise", rise, 4'b0000);
        check4("midrst_fall", fall, 4'b0000);
        check4("midrst_flags", flags, 4'b0000);
        rst = 1'b0;
        push(edge_n + 6, 4'b1001, 4'b0000, 4'b1001, 4'b1001);
        step(10);

        check_int("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/input_debounce.md
# input_debounce

Parametrised multi-channel input conditioner. It synchronises asynchronous level inputs into `clk`, debounces each channel independently, and reports clean levels, single-cycle edge pulses and sticky change flags. It sits at the chip boundary between raw pins (buttons, status lines) and core logic. It supersedes single-bit registered-input stages.

## Interface
- `WIDTH`, 4: number of independent channels, 1..32.
- `SYNC_STAGES`, 2: synchroniser flops per channel, 2..4.
- `DEBOUNCE_CYCLES`, 16: consecutive stable cycles required to accept a new level, 1..65535.
- `RESET_VAL`, 0: reset value (0 or 1) of every synchroniser stage and every `level_out` bit.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `en` in 1: debounce enable. When 0, counters are held at 0 and outputs are frozen.
- `in` in WIDTH: raw asynchronous inputs.
- `clr_flags` in WIDTH: per-channel clear for `flags`.
- `level_out` out WIDTH: debounced level, registered.
- `rise` out WIDTH: one-cycle pulse when `level_out[i]` goes 0→1.
- `fall` out WIDTH: one-cycle pulse when `level_out[i]` goes 1→0.
- `flags` out WIDTH: sticky bit, set on any accepted change of the channel.

## Operation
- Per channel i, a `SYNC_STAGES`-deep shift register samples `in[i]`. The last stage is `s[i]`. No logic sits between stages.
- Each channel has a counter of width `CNT_W = clog2(DEBOUNCE_CYCLES+1)`. There are no shared counters across channels.
- Per-channel FSM, evaluated each cycle:
  - STABLE (`s[i] == level_out[i]`): counter cleared to 0.
  - PENDING (`s[i] != level_out[i]`, `en=1`):
    - If counter == `DEBOUNCE_CYCLES-1`: `level_out[i] <= s[i]` and counter <= 0. Assert `rise[i]` if `s[i]=1`, otherwise `fall[i]`.
    - Otherwise: counter increments.
  - Any cycle where `s[i]` returns to `level_out[i]` before acceptance is a glitch. The counter clears, with no output change and no pulse.
- `en=0`:
  - Counters are cleared and `level_out` is held. `rise`/`fall` are 0.
  - The synchroniser keeps running.
  - After `en` returns to 1, a full `DEBOUNCE_CYCLES` must elapse before acceptance.
- `rise`/`fall` are registered, high for exactly one cycle, and coincide with the cycle `level_out` first shows the new value. `rise[i]` and `fall[i]` are never both high.
- `flags[i]` is set on the cycle after the pulse, i.e. registered from `rise[i]|fall[i]`. `clr_flags[i]=1` clears it. When set and clear occur in the same cycle, set wins.
- Channels are fully independent. Simultaneous events on multiple channels are all reported in the same cycle.
- No arithmetic overflow: the counter never exceeds `DEBOUNCE_CYCLES-1`.

## Timing
- Reset values (next edge with `rst=1`):
  - all synchroniser stages = `RESET_VAL`
  - `level_out` = {WIDTH{`RESET_VAL`}}
  - counters = 0
  - `rise` = `fall` = `flags` = 0
- Reset takes priority over all other inputs, including mid-debounce: counters are discarded and no pulse is emitted.
- After reset, an input already differing from `RESET_VAL` is debounced normally and produces one pulse.
- Latency: if `in[i]` changes before edge k and stays stable, `s[i]` changes after edge k+`SYNC_STAGES`-1. `level_out[i]`, `rise[i]` and `fall[i]` update after edge k+`SYNC_STAGES`-1+`DEBOUNCE_CYCLES`. Total: `SYNC_STAGES+DEBOUNCE_CYCLES` cycles.
- `flags` latency is one cycle more than `level_out`.
- Minimum accepted pulse width on `in` is `DEBOUNCE_CYCLES` cycles. Shorter pulses are always rejected.
- With `DEBOUNCE_CYCLES=1`, a change is accepted on the first cycle `s` differs from `level_out`.
- Maximum event rate per channel is one change per `DEBOUNCE_CYCLES` cycles.

## Test plan
All cases use `WIDTH=4`, `SYNC_STAGES=2`, `DEBOUNCE_CYCLES=4`, `RESET_VAL=0`.
- Basic rise: release reset, set `in`=4'b0001 before edge 0 and hold. Required: `level_out`=4'b0001 after edge 5 (6 cycles), with `rise`=4'b0001 for that one cycle only. `flags`=4'b0001 from edge 6.
- Glitch: `in[1]` high for 3 cycles, then low. Required: `level_out`, `rise`, `fall` and `flags` stay 0 throughout.
- Bounce: `in[2]` toggles 1,0,1,0,1 at 2-cycle intervals, then stays 1. Required: exactly one `rise[2]` pulse, 6 cycles after the final transition.
- Simultaneous events: from `level_out`=4'b1000, drive `in`=4'b0001 in one cycle. Required: `rise[0]` and `fall[3]` both pulse in the same cycle, and `flags`=4'b1001.
- Enable and flags: drop `en` to 0 after 2 pending cycles on ch0, hold `en` low 5 cycles, then restore. Required: no update while `en`=0, then acceptance 4 cycles after `en`=1. Assert `clr_flags[0]` in the same cycle `flags[0]` sets. Required: `flags[0]` stays 1. A later lone clear drops it to 0.
- Reset mid-debounce: assert `rst` for 1 cycle with ch3 counter at 2. Required: all outputs 0 next cycle, and no `rise`/`fall` pulse. If `in[3]` is still 1, acceptance follows 6 cycles after reset release.
